audio_feed_i2c_target: RTL and testbench
========================================

# audio_feed_i2c_target

I2C target (responder) with a 16 x 8-bit register file, acting as the far end of the bit-banged SCL/SDA initiator PIOs in the audio_feed system. It is used as an on-chip control target and as a loopback partner for exercising initiator software. It samples SCL/SDA, decodes START/STOP, matches a 7-bit device address, and supports pointer-addressed burst writes and reads with auto-increment. An Avalon-MM slave port gives the host direct access to the same register file.

## Interface
- DEV_ADDR, 7'h1A, 7-bit I2C device address this target answers to.
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pin level; asynchronous.
- sda_in  in  1  SDA pin level; asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- address  in  4  host register index.
- chipselect  in  1  host access strobe.
- write_n  in  1  active-low host write.
- writedata  in  32  host write data; only bits [7:0] are used.
- readdata  out  32  {24'b0, reg[address]}; combinational, zero wait states.
- busy  out  1  high from an address-matched START until the next STOP or release.

## Operation
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer, then a registered previous-value stage.
  - A rising or falling edge is defined as a difference between the synced and previous values.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Bit timing:
  - Data is sampled on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge, except that STOP, START and reset release it immediately.
- State machine states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE:
  - START -> ADDR, with bit_cnt=0.
- ADDR: shift in 8 bits, MSB first.
  - If addr[7:1]==DEV_ADDR -> ADDR_ACK. sda_oe=1 for the 9th clock; busy=1.
  - Otherwise -> IGNORE. SDA stays released (NACK).
- ADDR_ACK, at the falling edge ending the ACK:
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA. tx_shift is loaded with reg[ptr] and bit 7 is driven.
- PTR: 8 bits are received.
  - ptr <= byte[3:0]; bits [7:4] are ignored.
  - The byte is ACKed, then -> WDATA.
- WDATA: each received byte is written to reg[ptr], then ptr <= ptr+1 (4-bit wrap, 15 -> 0). The byte is ACKed and the state loops through WDATA_ACK.
- RDATA:
  - Drive sda_oe = ~tx_shift[7] on each falling edge.
  - After 8 bits -> RDATA_ACK with SDA released. The controller's ACK is sampled on the 9th rising edge.
  - ACK (SDA=0): ptr <= ptr+1; reload from the new ptr and continue in RDATA.
  - NACK: -> IGNORE, SDA released.
- IGNORE: SDA released until START or STOP.
- Global conditions:
  - START in any state -> ADDR (repeated start). ptr is retained.
  - STOP in any state -> IDLE, sda_oe=0, busy=0.
- Host access:
  - chipselect && ~write_n writes reg[address] <= writedata[7:0].
  - If the host and I2C write the same register in the same cycle, the host value wins.
  - ptr is not affected by host access.

## Timing
- Reset values: sda_oe=0, busy=0, state=IDLE, ptr=0, all registers 8'h00; readdata reflects the zeroed registers.
- sda_oe update latency: 3 clk after the pin-level SCL falling edge (2 sync + 1 edge register). SDA hold time is therefore set by the clk:SCL ratio.
- The I2C register write commits at the SCL rising edge of bit 8 plus 3 clk. A host read in the next cycle sees the new value.
- The read byte is latched at the falling edge that starts its bit 7. A host write after that point does not alter the byte already in flight.
- Reset asserted mid-transfer: SDA is released within the same cycle (async). After release, the bus is ignored until the next START.
- No clock stretching; SCL is never driven.

## Structure
- Package audio_feed_i2c_pkg holds:
  - the state enum;
  - REG_AW=4 and NUM_REGS=16;
  - default DEV_ADDR 7'h1A.
- Sub-module audio_feed_i2c_cond:
  - contains both synchronizers and edge registers;
  - outputs scl_rise, scl_fall, start_det, stop_det and sda_s.
- The top level contains the FSM, shift registers, bit counter, ptr, register file and Avalon port.

## Test plan
- Burst write: START, 0x34 (0x1A write), ptr 0x03, data 0xA5, 0x5A, STOP.
  - Required: all 4 bytes ACKed.
  - Required: host reads address 3 = 0x000000A5 and address 4 = 0x0000005A; busy returns to 0.
- Write then read via repeated start: START 0x34, ptr 0x03, repeated START, 0x35, read 2 bytes (ACK, then NACK).
  - Required: SDA returns 0xA5 then 0x5A; SDA is released after the NACK.
- Address mismatch: START 0x36 and one data byte.
  - Required: sda_oe stays 0 throughout; busy stays 0; registers are unchanged.
- Pointer wrap: ptr 0x0F, write 0x11, 0x22.
  - Required: reg15=0x11, reg0=0x22.
- Collision: the host writes 0x77 to reg 5 in the exact cycle the I2C commits 0x99 to reg 5.
  - Required: reg5=0x77.
- Reset mid-read: assert reset_n=0 while a read byte has SDA driven low.
  - Required: sda_oe=0 immediately and registers are 0.
  - Required: further SCL pulses are ignored until a new START.

Source files
------------

// File: rtl/audio_feed_i2c_pkg.sv
// audio_feed_i2c_pkg
// Shared definitions for the audio_feed I2C target: the protocol state
// encoding, register-file geometry and the default device address.
package audio_feed_i2c_pkg;

    localparam int unsigned REG_AW   = 4;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/audio_feed_i2c_cond.sv
// audio_feed_i2c_cond
// Brings the asynchronous SCL/SDA pin levels into the clk domain and
// derives the bus events used by the protocol FSM.
//   clk, reset_n   system clock, async active-low reset
//   scl_i, sda_i   raw pin levels
//   scl_rise_o     SCL rising edge (one clk pulse)
//   scl_fall_o     SCL falling edge (one clk pulse)
//   start_det_o    SDA fell while SCL high
//   stop_det_o     SDA rose while SCL high
//   sda_s_o        synchronized SDA level
module audio_feed_i2c_cond (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o,
    output logic sda_s_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;
    logic       sda_s;

    // Reset to the idle bus level so leaving reset creates no false events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    assign scl_rise_o  =  scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s &  scl_prev_q;
    // SCL must be high both before and after the SDA transition.
    assign start_det_o =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det_o  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;
    assign sda_s_o     =  sda_s;

endmodule

// File: rtl/audio_feed_i2c_target.sv
// audio_feed_i2c_target
// I2C target with a 16 x 8-bit register file. An I2C write sets the
// register pointer with its first data byte and then writes successive
// registers; an I2C read streams registers from the pointer. Both
// auto-increment with 4-bit wrap. An Avalon-MM slave port accesses the same
// registers with zero wait states; a host write wins over a same-cycle I2C
// write.
//   clk, reset_n          system clock, async active-low reset
//   scl_in, sda_in        bus pin levels (asynchronous)
//   sda_oe                1 = pull SDA low
//   address, chipselect,
//   write_n, writedata    host write port (writedata[7:0] used)
//   readdata              {24'b0, reg[address]}, combinational
//   busy                  address-matched transaction in progress
module audio_feed_i2c_target
    import audio_feed_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [REG_AW-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    audio_feed_i2c_cond u_cond (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_det_o(start_det),
        .stop_det_o (stop_det),
        .sda_s_o    (sda_s)
    );

    i2c_state_e        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d, rx_next;
    logic [7:0]        tx_q, tx_d;
    logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              i2c_we;
    logic [7:0]        regs_q [NUM_REGS];
    logic              host_we;
    logic              unused_wdata;

    assign rx_next = {rx_q[6:0], sda_s};
    assign ptr_inc = ptr_q + REG_AW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
        end
    end

    // Bits are counted on SCL rise; all SDA drive changes happen on SCL fall
    // once the counter shows the byte (8) is complete.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        i2c_we    = 1'b0;

        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        rx_d      = rx_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (rx_q[7:1] == DEV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rx_q[0]) begin
                            state_d = S_RDATA;
                            tx_d    = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                        end else begin
                            state_d = S_PTR;
                            oe_d    = 1'b0;
                        end
                    end
                end
                S_PTR: begin
                    if (scl_rise) begin
                        rx_d      = rx_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        ptr_d   = rx_q[REG_AW-1:0];
                        oe_d    = 1'b1;
                        state_d = S_PTR_ACK;
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        rx_d      = rx_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit on the 8th data bit, not at the ACK.
                        if (bit_cnt_q == 4'd7) begin
                            i2c_we = 1'b1;
                            ptr_d  = ptr_inc;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        state_d = S_WDATA_ACK;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = S_RDATA_ACK;
                        end else begin
                            tx_d = {tx_q[6:0], 1'b0};
                            oe_d = ~tx_q[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        rx_d = rx_next;
                    end else if (scl_fall) begin
                        if (!rx_q[0]) begin
                            ptr_d     = ptr_inc;
                            tx_d      = regs_q[ptr_inc];
                            oe_d      = ~regs_q[ptr_inc][7];
                            bit_cnt_d = '0;
                            state_d   = S_RDATA;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign host_we = chipselect & ~write_n;

    // Host write is ordered last so it overrides a same-cycle I2C write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (i2c_we) begin
                regs_q[ptr_q] <= rx_next;
            end
            if (host_we) begin
                regs_q[address] <= writedata[7:0];
            end
        end
    end

    assign unused_wdata = ^writedata[31:8];
    assign readdata     = {24'b0, regs_q[address]};
    assign sda_oe       = oe_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_audio_feed_i2c_target.sv
module tb_audio_feed_i2c_target;

    localparam int Q = 100;   // quarter SCL period in ns (10 clk)

    logic        clk = 1'b0;
    logic        reset_n;
    logic        scl;
    logic        tb_sda;
    logic        sda_line;
    logic        sda_oe;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic mon_en, mon_clr, oe_seen, busy_seen;

    always #5 clk = ~clk;

    assign sda_line = tb_sda & ~sda_oe;

    audio_feed_i2c_target #(.DEV_ADDR(7'h1A)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (mon_clr) begin
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else if (mon_en) begin
            if (sda_oe) oe_seen <= 1'b1;
            if (busy) busy_seen <= 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_read(input logic [3:0] a, output logic [31:0] v);
        address = a;
        #1 v = readdata;
        #9;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        address = a; writedata = {24'hFFFFFF, d}; chipselect = 1'b1; write_n = 1'b0;
        #10;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1; #Q;
        scl = 1'b1;    #Q;
        tb_sda = 1'b0; #Q;
        scl = 1'b0;    #Q;
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0; #Q;
        scl = 1'b1;    #Q;
        tb_sda = 1'b1; #Q;
    endtask

    // Returns the sampled ACK slot (0 = ACK). With coll set, a host write of
    // 0x77 to reg 5 is placed on the clk edge where bit 0 commits
    // (pin rise + 2 sync + 1 register = third posedge after the rise).
    task automatic write_byte(input logic [7:0] d, input bit coll, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            tb_sda = d[i]; #Q;
            scl = 1'b1;
            if (coll && i == 0) begin
                #20 host_write(4'd5, 8'h77);
                #(Q - 30);
            end else begin
                #Q;
            end
            #Q scl = 1'b0; #Q;
        end
        tb_sda = 1'b1; #Q;
        scl = 1'b1;    #Q;
        ack = sda_line; #Q;
        scl = 1'b0;    #Q;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            tb_sda = 1'b1; #Q;
            scl = 1'b1;    #Q;
            d[i] = sda_line; #Q;
            scl = 1'b0;    #Q;
        end
        tb_sda = ~give_ack; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
        tb_sda = 1'b1;
    endtask

    logic        ack;
    logic [7:0]  rd;
    logic [31:0] v;

    initial begin
        reset_n = 1'b0; scl = 1'b1; tb_sda = 1'b1;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        mon_en = 1'b0; mon_clr = 1'b1;
        #2;
        #40 reset_n = 1'b1;
        #40;

        // Reset state
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        host_read(4'd0, v);  check("rst_reg0", v, 32'h0);
        host_read(4'd15, v); check("rst_reg15", v, 32'h0);

        // Burst write 0xA5, 0x5A to reg 3..4
        i2c_start();
        write_byte(8'h34, 0, ack); check("bw_ack_addr", ack, 1'b0);
        check("bw_busy_mid", busy, 1'b1);
        write_byte(8'h03, 0, ack); check("bw_ack_ptr", ack, 1'b0);
        write_byte(8'hA5, 0, ack); check("bw_ack_d0", ack, 1'b0);
        write_byte(8'h5A, 0, ack); check("bw_ack_d1", ack, 1'b0);
        i2c_stop();
        #40;
        check("bw_busy_end", busy, 1'b0);
        host_read(4'd3, v); check("bw_reg3", v, 32'h000000A5);
        host_read(4'd4, v); check("bw_reg4", v, 32'h0000005A);

        // Set pointer, repeated start, read two bytes
        i2c_start();
        write_byte(8'h34, 0, ack); check("rd_ack_addr", ack, 1'b0);
        write_byte(8'h03, 0, ack); check("rd_ack_ptr", ack, 1'b0);
        i2c_start();
        write_byte(8'h35, 0, ack); check("rd_ack_raddr", ack, 1'b0);
        read_byte(1'b1, rd); check("rd_byte0", rd, 8'hA5);
        read_byte(1'b0, rd); check("rd_byte1", rd, 8'h5A);
        #Q;
        check("rd_release_after_nack", sda_oe, 1'b0);
        i2c_stop();
        #40;

        // Address mismatch
        mon_clr = 1'b1; #10 mon_clr = 1'b0; mon_en = 1'b1;
        i2c_start();
        write_byte(8'h36, 0, ack); check("mm_nack_addr", ack, 1'b1);
        write_byte(8'h09, 0, ack); check("mm_nack_data", ack, 1'b1);
        i2c_stop();
        #40 mon_en = 1'b0;
        check("mm_oe_seen", oe_seen, 1'b0);
        check("mm_busy_seen", busy_seen, 1'b0);
        host_read(4'd3, v); check("mm_reg3", v, 32'hA5);
        host_read(4'd4, v); check("mm_reg4", v, 32'h5A);
        host_read(4'd9, v); check("mm_reg9", v, 32'h0);

        // Pointer wrap 15 -> 0
        i2c_start();
        write_byte(8'h34, 0, ack);
        write_byte(8'h0F, 0, ack);
        write_byte(8'h11, 0, ack);
        write_byte(8'h22, 0, ack); check("wr_ack_last", ack, 1'b0);
        i2c_stop();
        #40;
        host_read(4'd15, v); check("wrap_reg15", v, 32'h11);
        host_read(4'd0, v);  check("wrap_reg0", v, 32'h22);

        // Same-cycle host / I2C write to reg 5
        i2c_start();
        write_byte(8'h34, 0, ack);
        write_byte(8'h05, 0, ack);
        write_byte(8'h99, 1, ack); check("coll_ack", ack, 1'b0);
        i2c_stop();
        #40;
        host_read(4'd5, v); check("coll_reg5", v, 32'h77);

        // Reset during a read byte whose MSB is 0 (reg 4 = 0x5A)
        i2c_start();
        write_byte(8'h34, 0, ack);
        write_byte(8'h04, 0, ack);
        i2c_start();
        write_byte(8'h35, 0, ack);
        check("rr_driving", sda_oe, 1'b1);
        reset_n = 1'b0;
        #1 check("rr_oe_async", sda_oe, 1'b0);
        #9;
        check("rr_busy", busy, 1'b0);
        host_read(4'd4, v); check("rr_reg4", v, 32'h0);
        host_read(4'd5, v); check("rr_reg5", v, 32'h0);
        reset_n = 1'b1;
        #20;
        mon_clr = 1'b1; #10 mon_clr = 1'b0; mon_en = 1'b1;
        write_byte(8'h34, 0, ack); check("rr_stray_nack", ack, 1'b1);
        mon_en = 1'b0;
        #10 check("rr_oe_seen", oe_seen, 1'b0);
        i2c_start();
        write_byte(8'h34, 0, ack); check("rr_new_start_ack", ack, 1'b0);
        i2c_stop();
        #40;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
